// File: rtl/detector_pkg.sv
// Shared types and constants for the serial pattern detector.
package detector_pkg;

  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic {
    DET_NON_OVERLAP = 1'b0,
    DET_OVERLAP     = 1'b1
  } det_mode_e;

  // Bits needed to count 0..n inclusive.
  function automatic int unsigned fill_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/detector_shift_reg.sv
// Serial history register plus saturating fill counter for the pattern detector.
module detector_shift_reg
  import detector_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned FW = fill_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift,
  input  logic         clear,
  input  logic         restart,
  input  logic         bit_in,
  output logic [N-1:0] hist_shift_c,
  output logic         full_shift_c
);

  logic [N-1:0]  hist;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_inc;

  generate
    if (N == 1) begin : g_one
      assign hist_shift_c = bit_in;
    end else begin : g_wide
      assign hist_shift_c = {hist[N-2:0], bit_in};
    end
  endgenerate

  assign fill_inc     = (fill == FW'(N)) ? fill : fill + FW'(1);
  assign full_shift_c = (fill_inc == FW'(N));

  // restart drops the fill so a non-overlapping match needs N fresh bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_shift_c;
      fill <= restart ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Run-time programmable serial bit-pattern detector with overlap control.
// Optional saturating match counter enabled by SEQ_PATTERN_DETECTOR_COUNT_EN.
module seq_pattern_detector
  import detector_pkg::*;
#(
  parameter int unsigned  N               = DEF_N,
  parameter logic [N-1:0] DEFAULT_PATTERN = N'(4'b1011),
  parameter int unsigned  CNT_W           = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In,
  input  logic             En,
  input  logic             Overlap,
  input  logic             Load,
  input  logic [N-1:0]     Pattern,
  input  logic             CntClr,
  output logic             Out,
  output logic [CNT_W-1:0] MatchCnt
);

  logic [N-1:0] pat;
  logic [N-1:0] hist_shift_c;
  logic         full_shift_c;
  logic         shift_c;
  logic         match_c;
  logic         restart_c;

  assign shift_c   = En & ~Load;
  assign match_c   = shift_c & full_shift_c & (hist_shift_c == pat);
  assign restart_c = match_c & (det_mode_e'(Overlap) == DET_NON_OVERLAP);

  detector_shift_reg #(.N(N)) u_shift_reg (
    .clk          (Clk),
    .rst          (Rst),
    .shift        (shift_c),
    .clear        (Load),
    .restart      (restart_c),
    .bit_in       (In),
    .hist_shift_c (hist_shift_c),
    .full_shift_c (full_shift_c)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pat <= DEFAULT_PATTERN;
      Out <= 1'b0;
    end else begin
      Out <= match_c;
      if (Load) pat <= Pattern;
    end
  end

`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear has priority over a coincident match.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      MatchCnt <= '0;
    end else if (CntClr) begin
      MatchCnt <= '0;
    end else if (match_c && (MatchCnt != CNT_MAX)) begin
      MatchCnt <= MatchCnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = CntClr;
  assign MatchCnt       = '0;
`endif

endmodule
